// File: rtl/edge_channel.sv
// One channel of the edge event detector: input synchronizer, edge
// history, pulse stretcher and sticky pending flag.
//
// Ports:
//   clk, rst    - clock and asynchronous active-high reset
//   signal_in   - asynchronous level input
//   rise_en     - enable for rising-edge events
//   fall_en     - enable for falling-edge events
//   pend_clr    - clears the pending flag (a new event wins over it)
//   edge_pulse  - registered pulse, PULSE_LEN cycles per event
//   pending     - sticky flag, set when the pulse starts
module edge_channel #(
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_LEN   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic signal_in,
    input  logic rise_en,
    input  logic fall_en,
    input  logic pend_clr,
    output logic edge_pulse,
    output logic pending
);

    localparam logic [7:0] RELOAD = 8'(PULSE_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   h;
    logic                   rise;
    logic                   fall;
    logic                   ev;
    logic                   ev_q;
    logic [7:0]             cnt;

    // Synchronizer chain; bit 0 samples the asynchronous input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], signal_in};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h <= 1'b0;
        end else begin
            h <= s;
        end
    end

    // Enables are applied only when the event is evaluated, so changing
    // them never touches a pulse that has already started.
    assign rise = s & ~h & rise_en;
    assign fall = ~s & h & fall_en;
    assign ev   = rise | fall;

    // The event is registered once before it reaches the stretcher, which
    // gives SYNC_STAGES+1 cycles from a settled input to the pulse edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ev_q <= 1'b0;
        end else begin
            ev_q <= ev;
        end
    end

    // Stretcher: a reload while the pulse is high extends it seamlessly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= 8'd0;
            edge_pulse <= 1'b0;
        end else if (ev_q) begin
            cnt        <= RELOAD;
            edge_pulse <= 1'b1;
        end else if (edge_pulse) begin
            if (cnt == 8'd0) begin
                edge_pulse <= 1'b0;
            end else begin
                cnt <= cnt - 8'd1;
            end
        end
    end

    // Set has priority over clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
        end else if (ev_q) begin
            pending <= 1'b1;
        end else if (pend_clr) begin
            pending <= 1'b0;
        end
    end

endmodule

// File: rtl/edge_event_detector.sv
// Multi-channel edge event detector: per-channel edge_channel instances,
// an OR of the pending flags and a lowest-index-first priority encoder.
//
// Ports:
//   clk, rst     - clock and asynchronous active-high reset
//   signal_in    - WIDTH asynchronous level inputs
//   rise_en      - per-channel rising-edge enable
//   fall_en      - per-channel falling-edge enable
//   pend_clr     - per-channel pending clear
//   edge_pulse   - per-channel stretched edge pulse
//   pending      - per-channel sticky event flags
//   any_pending  - OR of pending
//   first_idx    - lowest set pending index, 0 when none
module edge_event_detector #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_LEN   = 1,
    localparam int IDX_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] signal_in,
    input  logic [WIDTH-1:0] rise_en,
    input  logic [WIDTH-1:0] fall_en,
    input  logic [WIDTH-1:0] pend_clr,
    output logic [WIDTH-1:0] edge_pulse,
    output logic [WIDTH-1:0] pending,
    output logic             any_pending,
    output logic [IDX_W-1:0] first_idx
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        edge_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .PULSE_LEN   (PULSE_LEN)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .signal_in  (signal_in[i]),
            .rise_en    (rise_en[i]),
            .fall_en    (fall_en[i]),
            .pend_clr   (pend_clr[i]),
            .edge_pulse (edge_pulse[i]),
            .pending    (pending[i])
        );
    end

    assign any_pending = |pending;

    // Scan from the top down so the lowest set index is written last.
    always_comb begin
        first_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pending[i]) begin
                first_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: tb/tb_edge_event_detector.sv
// Directed bench for edge_event_detector with a scoreboard queue of
// expected outputs; two instances cover PULSE_LEN=1 and PULSE_LEN=4.
module tb_edge_event_detector;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] signal_in;
    logic [7:0] rise_en;
    logic [7:0] fall_en;
    logic [7:0] pend_clr;

    logic [7:0] pulse1;
    logic [7:0] pend1;
    logic       any1;
    logic [2:0] idx1;
    logic [7:0] pulse4;
    logic [7:0] pend4;
    logic       any4;
    logic [2:0] idx4;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string      tag;
        bit         long_dut;
        logic [7:0] pulse;
        logic [7:0] pend;
        logic [2:0] idx;
        logic       any;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    edge_event_detector #(
        .WIDTH       (8),
        .SYNC_STAGES (2),
        .PULSE_LEN   (1)
    ) dut1 (
        .clk         (clk),
        .rst         (rst),
        .signal_in   (signal_in),
        .rise_en     (rise_en),
        .fall_en     (fall_en),
        .pend_clr    (pend_clr),
        .edge_pulse  (pulse1),
        .pending     (pend1),
        .any_pending (any1),
        .first_idx   (idx1)
    );

    edge_event_detector #(
        .WIDTH       (8),
        .SYNC_STAGES (2),
        .PULSE_LEN   (4)
    ) dut4 (
        .clk         (clk),
        .rst         (rst),
        .signal_in   (signal_in),
        .rise_en     (rise_en),
        .fall_en     (fall_en),
        .pend_clr    (pend_clr),
        .edge_pulse  (pulse4),
        .pending     (pend4),
        .any_pending (any4),
        .first_idx   (idx4)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect1(input string tag, input logic [7:0] p,
                           input logic [7:0] pd, input logic [2:0] ix,
                           input logic an);
        exp_t e;
        e.tag      = tag;
        e.long_dut = 1'b0;
        e.pulse    = p;
        e.pend     = pd;
        e.idx      = ix;
        e.any      = an;
        sb.push_back(e);
    endtask

    task automatic expect4(input string tag, input logic [7:0] p);
        exp_t e;
        e.tag      = tag;
        e.long_dut = 1'b1;
        e.pulse    = p;
        e.pend     = '0;
        e.idx      = '0;
        e.any      = 1'b0;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL scoreboard_empty: observed 0 entries required 1");
            return;
        end
        e = sb.pop_front();
        if (e.long_dut) begin
            n_checks++;
            assert (pulse4 === e.pulse) else begin
                n_fail++;
                $error("FAIL %s pulse4: observed %02h required %02h",
                       e.tag, pulse4, e.pulse);
            end
        end else begin
            n_checks++;
            assert (pulse1 === e.pulse) else begin
                n_fail++;
                $error("FAIL %s edge_pulse: observed %02h required %02h",
                       e.tag, pulse1, e.pulse);
            end
            n_checks++;
            assert (pend1 === e.pend) else begin
                n_fail++;
                $error("FAIL %s pending: observed %02h required %02h",
                       e.tag, pend1, e.pend);
            end
            n_checks++;
            assert (idx1 === e.idx) else begin
                n_fail++;
                $error("FAIL %s first_idx: observed %0d required %0d",
                       e.tag, idx1, e.idx);
            end
            n_checks++;
            assert (any1 === e.any) else begin
                n_fail++;
                $error("FAIL %s any_pending: observed %0b required %0b",
                       e.tag, any1, e.any);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        signal_in = 8'h00;
        rise_en   = 8'hFF;
        fall_en   = 8'h00;
        pend_clr  = 8'h00;
        tick(3);
        expect1("reset", 8'h00, 8'h00, 3'd0, 1'b0);
        check();
        rst = 1'b0;
        tick(2);

        // Rising edge latency on channel 3.
        signal_in = 8'h08;
        tick(3);
        expect1("lat_early", 8'h00, 8'h00, 3'd0, 1'b0);
        check();
        tick();
        expect1("lat_pulse", 8'h08, 8'h08, 3'd3, 1'b1);
        check();
        tick();
        expect1("lat_end", 8'h00, 8'h08, 3'd3, 1'b1);
        check();
        pend_clr = 8'h08;
        tick();
        pend_clr = 8'h00;
        expect1("clr3", 8'h00, 8'h00, 3'd0, 1'b0);
        check();

        // Falling-only on channel 0.
        rise_en   = 8'hFE;
        fall_en   = 8'h01;
        signal_in = 8'h09;
        tick(6);
        expect1("fall_norise", 8'h00, 8'h00, 3'd0, 1'b0);
        check();
        signal_in = 8'h08;
        tick(4);
        expect1("fall_pulse", 8'h01, 8'h01, 3'd0, 1'b1);
        check();
        tick();
        expect1("fall_end", 8'h00, 8'h01, 3'd0, 1'b1);
        check();
        signal_in = 8'h09;
        tick(4);
        expect1("fall_rise_ignored", 8'h00, 8'h01, 3'd0, 1'b1);
        check();
        tick(3);
        pend_clr = 8'h01;
        tick();
        pend_clr = 8'h00;
        expect1("clr0", 8'h00, 8'h00, 3'd0, 1'b0);
        check();

        // Both edges on channel 0.
        rise_en   = 8'hFF;
        signal_in = 8'h08;
        tick(4);
        expect1("both_fall", 8'h01, 8'h01, 3'd0, 1'b1);
        check();
        tick(3);
        signal_in = 8'h09;
        tick(4);
        expect1("both_rise", 8'h01, 8'h01, 3'd0, 1'b1);
        check();
        tick(3);
        pend_clr = 8'h01;
        tick();
        pend_clr = 8'h00;
        expect1("clr0_both", 8'h00, 8'h00, 3'd0, 1'b0);
        check();

        // Stretch and retrigger on channel 7 of the PULSE_LEN=4 instance.
        fall_en   = 8'h81;
        signal_in = 8'h89;
        tick(2);
        signal_in = 8'h09;
        expect4("stretch_pre", 8'h00);
        for (int i = 0; i < 6; i++) begin
            expect4("stretch_high", 8'h80);
        end
        expect4("stretch_low", 8'h00);
        repeat (8) begin
            tick();
            check();
        end
        tick(3);
        pend_clr = 8'hFF;
        tick();
        pend_clr = 8'h00;
        expect1("clr_all", 8'h00, 8'h00, 3'd0, 1'b0);
        check();

        // Set beats clear on channel 5.
        signal_in = 8'h29;
        tick(3);
        pend_clr = 8'h20;
        tick();
        pend_clr = 8'h00;
        expect1("set_wins", 8'h20, 8'h20, 3'd5, 1'b1);
        check();
        tick();
        expect1("set_hold", 8'h00, 8'h20, 3'd5, 1'b1);
        check();
        pend_clr = 8'h20;
        tick();
        pend_clr = 8'h00;
        expect1("clr5", 8'h00, 8'h00, 3'd0, 1'b0);
        check();

        // Priority encoder with channels 2 and 6.
        signal_in = 8'h6D;
        tick(4);
        expect1("prio_both", 8'h44, 8'h44, 3'd2, 1'b1);
        check();
        pend_clr = 8'h04;
        tick();
        pend_clr = 8'h00;
        expect1("prio_clr2", 8'h00, 8'h40, 3'd6, 1'b1);
        check();
        pend_clr = 8'h40;
        tick();
        pend_clr = 8'h00;
        expect1("prio_clr6", 8'h00, 8'h00, 3'd0, 1'b0);
        check();

        // Asynchronous reset in the middle of a pulse.
        fall_en   = 8'hFF;
        signal_in = 8'h00;
        tick(4);
        expect1("pre_rst", 8'h6D, 8'h6D, 3'd0, 1'b1);
        check();
        expect4("pre_rst4", 8'h6D);
        check();
        #2;
        rst       = 1'b1;
        signal_in = 8'hFF;
        #1;
        expect1("rst_async", 8'h00, 8'h00, 3'd0, 1'b0);
        check();
        expect4("rst_async4", 8'h00);
        check();
        tick(3);
        rst = 1'b0;
        tick(3);
        expect1("rel_early", 8'h00, 8'h00, 3'd0, 1'b0);
        check();
        tick();
        expect1("rel_pulse", 8'hFF, 8'hFF, 3'd0, 1'b1);
        check();
        expect4("rel_pulse4", 8'hFF);
        check();
        tick();
        expect1("rel_end", 8'h00, 8'hFF, 3'd0, 1'b1);
        check();
        tick(8);
        expect1("rel_once", 8'h00, 8'hFF, 3'd0, 1'b1);
        check();
        expect4("rel_once4", 8'h00);
        check();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/edge_event_detector.md
EDGE_EVENT_DETECTOR -- requirements
Module: edge_event_detector

Interface
REQ-001 Parameter WIDTH, default 8, is the number of independent input channels (1..32).
REQ-002 Parameter SYNC_STAGES, default 2, is the number of synchronizer flops per channel (2..4).
REQ-003 Parameter PULSE_LEN, default 1, is the output pulse length in cycles (1..255).
REQ-004 Port clk, input, 1, is the single clock; all state is clocked on its rising edge.
REQ-005 Port rst, input, 1, is an asynchronous, active-high reset.
REQ-006 Port signal_in, input, WIDTH, carries asynchronous level inputs.
REQ-007 Port rise_en, input, WIDTH, enables rising-edge detection per channel.
REQ-008 Port fall_en, input, WIDTH, enables falling-edge detection per channel.
REQ-009 Port pend_clr, input, WIDTH, is a one-hot or multi-hot pending-flag clear, sampled each cycle.
REQ-010 Port edge_pulse, output, WIDTH, is the per-channel stretched, registered edge pulse.
REQ-011 Port pending, output, WIDTH, holds the per-channel sticky event flags.
REQ-012 Port any_pending, output, 1, is the OR of pending.
REQ-013 Port first_idx, output, clog2(WIDTH) (min 1), is the lowest-numbered set pending bit, and 0 when none is set.

Function
REQ-014 Each channel SHALL pass signal_in[i] through SYNC_STAGES flops to produce s[i], then register s[i] into history h[i].
REQ-015 A rising event SHALL be s&~h&rise_en; a falling event SHALL be ~s&h&fall_en; ev = rise|fall.
REQ-016 Latency: an input transition that is stable before clock edge N SHALL assert edge_pulse after edge N+SYNC_STAGES+1.
REQ-017 On ev, the per-channel 8-bit stretch counter SHALL load PULSE_LEN-1 and edge_pulse SHALL go high at the next edge.
REQ-018 edge_pulse SHALL remain high for exactly PULSE_LEN cycles, decrementing once per cycle, and SHALL then go low.
REQ-019 A new ev while the pulse is still high SHALL reload the counter (retrigger), so the pulse extends with no low gap.
REQ-020 pending[i] SHALL set on the same edge at which edge_pulse[i] first rises.
REQ-021 pending[i] SHALL clear on the edge after pend_clr[i] is high.
REQ-022 If set and clear occur in the same cycle, set SHALL win.
REQ-023 Toggling rise_en or fall_en SHALL affect only events evaluated in that cycle and SHALL NOT alter pulses in progress.
REQ-024 any_pending and first_idx SHALL be combinational from the pending register; first_idx SHALL use the lowest index as highest priority.
REQ-025 Channels SHALL be fully independent; simultaneous events on all channels SHALL all be captured.

Reset
REQ-026 rst SHALL clear all synchronizer flops, h, stretch counters, edge_pulse, and pending to 0; any_pending and first_idx SHALL read 0.
REQ-027 After rst deasserts, an input held high SHALL produce exactly one rising event, when rise_en is set.
REQ-028 rst asserted mid-pulse SHALL drop edge_pulse within the same cycle, since reset is asynchronous.

Structure
REQ-029 No shared package SHALL be used; the width constants are derived locally from the parameters.
REQ-030 Per-channel logic SHALL live in sub-module edge_channel (sync chain, history, stretch counter, pending flag), instantiated by a generate loop.
REQ-031 The top level SHALL contain only the generate loop, the OR reduction, and the priority encoder.

Verification
REQ-032 Bench SHALL check rising-edge latency: WIDTH=8, SYNC_STAGES=2, PULSE_LEN=1, rise_en=FF; signal_in[3] goes 0->1 before edge 10 -> edge_pulse=08 for one cycle after edge 13, pending=08, first_idx=3.
REQ-033 Bench SHALL check falling-only and both-edge modes: fall_en[0]=1, rise_en[0]=0; a 1->0->1 input yields one pulse; with both enables set, the same input yields two pulses.
REQ-034 Bench SHALL check stretch and retrigger: PULSE_LEN=4; edges 2 cycles apart produce a single pulse 6 cycles long.
REQ-035 Bench SHALL check clear-versus-set priority: pend_clr[5] asserted in the same cycle as a new ch5 event leaves pending[5]=1; a clear alone drops it next cycle.
REQ-036 Bench SHALL check the priority encoder: events on ch2 and ch6 together -> first_idx=2; clearing ch2 -> first_idx=6; clearing ch6 -> any_pending=0, first_idx=0.
REQ-037 Bench SHALL check reset: rst asserted mid-pulse -> all outputs 0 immediately; after release with signal_in=FF, exactly one pulse per channel.
